// File: rtl/debug_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug command sequencer and the debug harness:
// harness opcodes, host status codes, the sequencer state encoding and small
// helpers for opcode legality and status byte packing.
// -----------------------------------------------------------------------------
package debug_pkg;

    // Harness opcodes (debug_cmd encoding)
    localparam logic [3:0] CMD_IDLE = 4'd0;
    localparam logic [3:0] CMD_RUN  = 4'd1;
    localparam logic [3:0] CMD_HALT = 4'd2;
    localparam logic [3:0] CMD_STEP = 4'd3;

    // Status codes returned in resp_data[7:6]
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BADCMD  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_RESP    = 2'd3
    } seq_state_t;

    // Opcodes above STEP have no meaning to the harness
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= CMD_STEP);
    endfunction

    // Status byte layout: [7:6] status, [5:4] zero, [3:0] echoed opcode
    function automatic logic [7:0] pack_resp(input logic [1:0] st, input logic [3:0] op);
        return {st, 2'b00, op};
    endfunction

endpackage

// File: rtl/debug_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// debug_cmd_sequencer_if
// Host link of the sequencer: command byte channel (host_valid/host_ready/
// host_data) and status byte channel (resp_valid/resp_ready/resp_data).
//   master : host side (Python UI link / testbench)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface debug_cmd_sequencer_if;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_data;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;

    modport master (
        output host_valid, host_data, resp_ready,
        input  host_ready, resp_valid, resp_data
    );

    modport slave (
        input  host_valid, host_data, resp_ready,
        output host_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/debug_cmd_sequencer_timeout_ctr.sv
// -----------------------------------------------------------------------------
// debug_timeout_ctr
// Saturating wait counter. Cleared by clr, counts up while en is high and
// flags expired once the count reaches TIMEOUT_CYC.
// Ports: clk, reset_n (sync, active-low), clr, en, expired.
// -----------------------------------------------------------------------------
module debug_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] cnt_r;

    // Wait counter: clear has priority, saturates at LIMIT so it never wraps
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/debug_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// debug_cmd_sequencer
// Accepts command bytes from the host link, drives the harness debug_cmd,
// waits for command_complete, repeats N+1 times, and returns one status
// byte per command. A wait timeout aborts a hung command.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   host               host link (command in / status out), slave modport
//   debug_cmd          opcode to the harness (0 = harness IDLE)
//   command_complete   harness acknowledge
//   busy               high whenever not in S_IDLE
// -----------------------------------------------------------------------------
module debug_cmd_sequencer
    import debug_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    debug_cmd_sequencer_if.slave         host,
    output logic [3:0]                   debug_cmd,
    input  logic                         command_complete,
    output logic                         busy
);

    seq_state_t state_r, next_state_s;
    logic [3:0] op_r, op_s;
    logic [3:0] rpt_r, rpt_s;
    logic [1:0] status_r, status_s;
    logic       issue_done_s;
    logic       expired_s;
    logic       to_clr_s;
    logic       to_en_s;

    logic [3:0] debug_cmd_r;
    logic       host_ready_r;
    logic       resp_valid_r;
    logic [7:0] resp_data_r;
    logic       busy_r;

    // Opcode IDLE has no acknowledge of its own: a low command_complete is its completion
    assign issue_done_s = (op_r == CMD_IDLE) ? !command_complete : command_complete;

    // Timer restarts on each entry into a waiting state and runs while in one
    assign to_en_s  = (state_r == S_ISSUE) || (state_r == S_RELEASE);
    assign to_clr_s = (next_state_s != state_r) &&
                      ((next_state_s == S_ISSUE) || (next_state_s == S_RELEASE));

    debug_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (to_clr_s),
        .en      (to_en_s),
        .expired (expired_s)
    );

    // Next-state and latched command/status decode; exit conditions beat timeout
    always_comb begin
        next_state_s = state_r;
        op_s         = op_r;
        rpt_s        = rpt_r;
        status_s     = status_r;
        case (state_r)
            S_IDLE: begin
                if (host.host_valid) begin
                    op_s  = host.host_data[3:0];
                    rpt_s = host.host_data[7:4];
                    if (is_legal_op(host.host_data[3:0])) begin
                        next_state_s = S_ISSUE;
                        status_s     = ST_OK;
                    end else begin
                        next_state_s = S_RESP;
                        status_s     = ST_BADCMD;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (issue_done_s) begin
                    next_state_s = S_RELEASE;
                end else if (expired_s) begin
                    next_state_s = S_RESP;
                    status_s     = ST_TIMEOUT;
                end else begin
                    next_state_s = S_ISSUE;
                end
            end
            S_RELEASE: begin
                if (!command_complete) begin
                    if (rpt_r != 4'd0) begin
                        rpt_s        = rpt_r - 4'd1;
                        next_state_s = S_ISSUE;
                    end else begin
                        next_state_s = S_RESP;
                        status_s     = ST_OK;
                    end
                end else if (expired_s) begin
                    next_state_s = S_RESP;
                    status_s     = ST_TIMEOUT;
                end else begin
                    next_state_s = S_RELEASE;
                end
            end
            S_RESP: begin
                if (host.resp_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State and latched command registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            op_r     <= 4'd0;
            rpt_r    <= 4'd0;
            status_r <= ST_OK;
        end else begin
            state_r  <= next_state_s;
            op_r     <= op_s;
            rpt_r    <= rpt_s;
            status_r <= status_s;
        end
    end

    // Output registers, loaded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            debug_cmd_r  <= 4'd0;
            host_ready_r <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 8'h00;
            busy_r       <= 1'b0;
        end else begin
            debug_cmd_r  <= (next_state_s == S_ISSUE) ? op_s : CMD_IDLE;
            host_ready_r <= (next_state_s == S_IDLE);
            resp_valid_r <= (next_state_s == S_RESP);
            resp_data_r  <= (next_state_s == S_RESP) ? pack_resp(status_s, op_s) : resp_data_r;
            busy_r       <= (next_state_s != S_IDLE);
        end
    end

    assign debug_cmd       = debug_cmd_r;
    assign host.host_ready = host_ready_r;
    assign host.resp_valid = resp_valid_r;
    assign host.resp_data  = resp_data_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_debug_cmd_sequencer
// Directed bench for debug_cmd_sequencer with a one-cycle-late harness model
// (command_complete follows debug_cmd != 0 by one cycle when enabled).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_debug_cmd_sequencer;

    localparam int TIMEOUT_CYC = 16;
    localparam int TO_W        = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] debug_cmd;
    logic       command_complete;
    logic       busy;
    logic       harness_en = 1'b1;
    logic       ack_r = 1'b0;

    int checks = 0;
    int errors = 0;

    debug_cmd_sequencer_if host_if ();

    debug_cmd_sequencer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .host             (host_if.slave),
        .debug_cmd        (debug_cmd),
        .command_complete (command_complete),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Harness model: acknowledges one cycle after a non-idle opcode appears
    always @(posedge clk) begin
        if (!reset_n) ack_r <= 1'b0;
        else          ack_r <= harness_en && (debug_cmd != 4'd0);
    end
    assign command_complete = ack_r;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a byte for one edge (state must be S_IDLE); returns at negedge of cycle T+1
    task automatic send_byte(input logic [7:0] b);
        host_if.host_valid = 1'b1;
        host_if.host_data  = b;
        @(negedge clk);
        host_if.host_valid = 1'b0;
    endtask

    // Send a byte, wait (bounded) for the response; lat is the cycle index after acceptance
    task automatic issue_and_wait(input logic [7:0] b, output int lat, output int ones,
                                  output int rises, output logic [7:0] rd, output logic [3:0] cmd_at_resp);
        logic prev_ack;
        lat = -1; ones = 0; rises = 0; rd = 8'h00; cmd_at_resp = 4'hF;
        prev_ack = command_complete;
        send_byte(b);
        for (int n = 1; n <= 100; n++) begin
            if (host_if.resp_valid) begin
                lat = n;
                rd = host_if.resp_data;
                cmd_at_resp = debug_cmd;
                break;
            end
            if (debug_cmd != 4'd0) ones++;
            if (command_complete && !prev_ack) rises++;
            prev_ack = command_complete;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int         lat, ones, rises;
        logic [7:0] rd;
        logic [3:0] cr;
        logic [3:0] exp_seq [4];

        exp_seq = '{4'd3, 4'd3, 4'd0, 4'd0};
        host_if.host_valid = 1'b0;
        host_if.host_data  = 8'h00;
        host_if.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_value("rst_host_ready", host_if.host_ready, 1);
        check_value("rst_debug_cmd", debug_cmd, 0);
        check_value("rst_resp_valid", host_if.resp_valid, 0);
        check_value("rst_resp_data", host_if.resp_data, 0);
        check_value("rst_busy", busy, 0);
        @(negedge clk);

        // STEP single issue: debug_cmd 3,3,0,0 then response at T+5
        send_byte(8'h03);
        check_value("step_busy", busy, 1);
        check_value("step_host_ready", host_if.host_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("step_cmd_%0d", i + 1), debug_cmd, exp_seq[i]);
            @(negedge clk);
        end
        check_value("step_resp_valid", host_if.resp_valid, 1);
        check_value("step_resp_data", host_if.resp_data, 8'h03);
        @(negedge clk);
        check_value("step_busy_after", busy, 0);
        check_value("step_ready_after", host_if.host_ready, 1);

        // RUN with N=2: three acknowledges, 4 cycles per issue
        issue_and_wait(8'h21, lat, ones, rises, rd, cr);
        check_value("run_latency", lat, 13);
        check_value("run_ack_pulses", rises, 3);
        check_value("run_cmd_cycles", ones, 6);
        check_value("run_resp", rd, 8'h01);

        // IDLE opcode with N=1: completes without any acknowledge
        issue_and_wait(8'h10, lat, ones, rises, rd, cr);
        check_value("idle_latency", lat, 5);
        check_value("idle_resp", rd, 8'h00);

        // Illegal opcode: response one cycle after acceptance, harness untouched
        send_byte(8'h07);
        check_value("bad_resp_valid", host_if.resp_valid, 1);
        check_value("bad_resp_data", host_if.resp_data, 8'h87);
        check_value("bad_cmd", debug_cmd, 0);
        @(negedge clk);
        check_value("bad_cmd_after", debug_cmd, 0);

        // Timeout: harness never acks; counter reaches 16 on the 17th ISSUE cycle
        harness_en = 1'b0;
        issue_and_wait(8'h02, lat, ones, rises, rd, cr);
        check_value("to_latency", lat, TIMEOUT_CYC + 2);
        check_value("to_cmd_cycles", ones, TIMEOUT_CYC + 1);
        check_value("to_resp", rd, 8'h42);
        check_value("to_cmd_at_resp", cr, 0);
        harness_en = 1'b1;

        // Response backpressure with a byte offered meanwhile
        host_if.resp_ready = 1'b0;
        send_byte(8'h05);
        host_if.host_valid = 1'b1;
        host_if.host_data  = 8'h01;
        for (int i = 0; i < 10; i++) begin
            check_value($sformatf("bp_valid_%0d", i), host_if.resp_valid, 1);
            check_value($sformatf("bp_data_%0d", i), host_if.resp_data, 8'h85);
            check_value($sformatf("bp_ready_%0d", i), host_if.host_ready, 0);
            @(negedge clk);
        end
        host_if.host_valid = 1'b0;
        host_if.resp_ready = 1'b1;
        @(negedge clk);
        check_value("bp_idle_busy", busy, 0);
        check_value("bp_idle_ready", host_if.host_ready, 1);
        check_value("bp_not_taken", debug_cmd, 0);
        @(negedge clk);
        check_value("bp_not_taken2", debug_cmd, 0);

        // Reset during S_ISSUE of 0xF3, then a normal RUN
        send_byte(8'hF3);
        check_value("mid_cmd_before", debug_cmd, 3);
        reset_n = 1'b0;
        @(negedge clk);
        check_value("mid_rst_cmd", debug_cmd, 0);
        check_value("mid_rst_ready", host_if.host_ready, 1);
        check_value("mid_rst_resp_valid", host_if.resp_valid, 0);
        check_value("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        issue_and_wait(8'h01, lat, ones, rises, rd, cr);
        check_value("post_rst_latency", lat, 5);
        check_value("post_rst_acks", rises, 1);
        check_value("post_rst_resp", rd, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
